line_clear_ctrl: RTL and testbench



---
 rtl/line_clear_ctrl.sv | 86 ++++++++
 tb/tb_line_clear_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans playfield rows bottom-to-top after a piece locks,
// collapses every full row by advancing all rows at or above it, and arbitrates grid writes.
module line_clear_ctrl #(
   parameter int ROWS = 20,
   parameter int CW   = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [ROWS-1:0] row_full,
   input  logic            wr_req,
   output logic            wr_gnt,
   output logic [ROWS-1:0] advance,
   output logic            busy,
   output logic            done,
   output logic [CW-1:0]   lines_cleared
);

   typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

   state_t        state;
   logic [CW-1:0] r;
   logic [ROWS-1:0] shift_mask;

   // Rows 0..r take the contents of the row above; row 0 loads the tied-off empty row.
   always_comb begin
      shift_mask = '0;
      for (int i = 0; i < ROWS; i++) begin
         shift_mask[i] = (CW'(i) <= r);
      end
   end

   // The piece writer only gets the grid while idle and not in the cycle a pass is launched.
   assign wr_gnt = wr_req && (state == IDLE) && !start && !reset;

   // A SHIFT always returns to SCAN at the same row, so the row that slid down is re-checked.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         r             <= CW'(ROWS - 1);
         advance       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         lines_cleared <= '0;
      end else begin
         advance <= '0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  lines_cleared <= '0;
                  r             <= CW'(ROWS - 1);
                  busy          <= 1'b1;
                  state         <= SCAN;
               end
            end
            SCAN: begin
               if (row_full[r]) begin
                  advance <= shift_mask;
                  state   <= SHIFT;
               end else if (r == '0) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  r <= r - 1'b1;
               end
            end
            SHIFT: begin
               if (lines_cleared != '1) begin
                  lines_cleared <= lines_cleared + 1'b1;
               end
               state <= SCAN;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Testbench for line_clear_ctrl: drives a behavioural row-register grid and checks each
// pass against a model that derives shift times, masks and the final grid from the clearing rules.
module tb_line_clear_ctrl;

   localparam int ROWS = 20;
   localparam int CW   = 5;
   localparam int W    = 10;
   localparam logic [W-1:0] FULL_ROW = '1;

   logic            clk;
   logic            reset;
   logic            start;
   logic [ROWS-1:0] row_full;
   logic            wr_req;
   logic            wr_gnt;
   logic [ROWS-1:0] advance;
   logic            busy;
   logic            done;
   logic [CW-1:0]   lines_cleared;

   logic [W-1:0] grid[ROWS];
   logic [W-1:0] load_val[ROWS];
   logic         load;

   int n_checks;
   int n_fail;

   line_clear_ctrl #(.ROWS(ROWS), .CW(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .row_full(row_full),
      .wr_req(wr_req), .wr_gnt(wr_gnt), .advance(advance), .busy(busy),
      .done(done), .lines_cleared(lines_cleared)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memcell grid stand-in: each row register loads the row above when advanced.
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < ROWS; i++) grid[i] <= load_val[i];
      end else begin
         if (advance[0]) grid[0] <= '0;
         for (int i = 1; i < ROWS; i++) begin
            if (advance[i]) grid[i] <= grid[i-1];
         end
      end
   end

   always_comb begin
      row_full = '0;
      for (int i = 0; i < ROWS; i++) row_full[i] = &grid[i];
   end

   task automatic load_grid();
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // One full clear pass: model predicts shift cycles/masks, done time and resulting grid.
   task automatic test_clear_pass(input string name, input bit wrreq, input bit inject);
      logic [W-1:0]    snap[ROWS];
      logic [W-1:0]    exp_grid[ROWS];
      logic [ROWS-1:0] exp_adv[128];
      int c, p, m, done_t, sc;
      for (int k = 0; k < 128; k++) exp_adv[k] = '0;
      for (int j = 0; j < ROWS; j++) snap[j] = grid[j];
      c = 0;
      for (int j = ROWS - 1; j >= 0; j--) begin
         if (snap[j] == FULL_ROW) begin
            p  = j + c;
            sc = 2 + 2 * c + (ROWS - 1 - p);
            for (int b = 0; b <= p; b++) exp_adv[sc][b] = 1'b1;
            c++;
         end
      end
      done_t = ROWS + 2 * c + 1;
      for (int j = 0; j < ROWS; j++) exp_grid[j] = '0;
      m = ROWS - 1;
      for (int j = ROWS - 1; j >= 0; j--) begin
         if (snap[j] != FULL_ROW) begin
            exp_grid[m] = snap[j];
            m--;
         end
      end

      @(negedge clk);
      wr_req = wrreq;
      #1;
      n_checks++;
      if (wr_gnt !== wrreq) begin
         n_fail++;
         $display("[TB] FAIL %s idle wr_gnt: got %b exp %b", name, wr_gnt, wrreq);
      end
      start = 1'b1;
      #1;
      n_checks++;
      if (wr_gnt !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL %s start-cycle wr_gnt: got %b exp 0", name, wr_gnt);
      end

      for (int k = 1; k <= done_t + 1; k++) begin
         @(negedge clk);
         n_checks++;
         if (advance !== exp_adv[k]) begin
            n_fail++;
            $display("[TB] FAIL %s advance cyc t+%0d: got %h exp %h", name, k, advance, exp_adv[k]);
         end
         n_checks++;
         if (busy !== (k <= done_t)) begin
            n_fail++;
            $display("[TB] FAIL %s busy cyc t+%0d: got %b exp %b", name, k, busy, (k <= done_t));
         end
         n_checks++;
         if (done !== (k == done_t)) begin
            n_fail++;
            $display("[TB] FAIL %s done cyc t+%0d: got %b exp %b", name, k, done, (k == done_t));
         end
         n_checks++;
         if (wr_gnt !== (wrreq && k > done_t)) begin
            n_fail++;
            $display("[TB] FAIL %s wr_gnt cyc t+%0d: got %b exp %b", name, k, wr_gnt, (wrreq && k > done_t));
         end
         if (k >= done_t) begin
            n_checks++;
            if (lines_cleared !== CW'(c)) begin
               n_fail++;
               $display("[TB] FAIL %s lines_cleared cyc t+%0d: got %0d exp %0d", name, k, lines_cleared, c);
            end
         end
         start = (inject && k == 4);
      end
      start = 1'b0;

      for (int j = 0; j < ROWS; j++) begin
         n_checks++;
         if (grid[j] !== exp_grid[j]) begin
            n_fail++;
            $display("[TB] FAIL %s grid row %0d: got %h exp %h", name, j, grid[j], exp_grid[j]);
         end
      end
   endtask

   task automatic test_reset();
      wr_req = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, done, advance, lines_cleared, wr_gnt} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset outputs: got busy=%b done=%b adv=%h lc=%0d gnt=%b exp all 0",
                  busy, done, advance, lines_cleared, wr_gnt);
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (wr_gnt !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset idle wr_gnt: got %b exp 1", wr_gnt);
      end
      wr_req = 1'b0;
   endtask

   task automatic test_empty_grid();
      for (int j = 0; j < ROWS; j++) load_val[j] = W'(j);
      load_grid();
      test_clear_pass("empty", 1'b0, 1'b0);
   endtask

   task automatic test_single_row();
      for (int j = 0; j < ROWS; j++) load_val[j] = W'(j + 1);
      load_val[19] = FULL_ROW;
      load_grid();
      test_clear_pass("row19", 1'b0, 1'b0);
   endtask

   task automatic test_tetris();
      for (int j = 0; j < ROWS; j++) load_val[j] = W'(j + 3);
      for (int j = 16; j < ROWS; j++) load_val[j] = FULL_ROW;
      load_grid();
      test_clear_pass("tetris", 1'b0, 1'b0);
   endtask

   task automatic test_split_rows();
      for (int j = 0; j < ROWS; j++) load_val[j] = W'(j * 7 + 1);
      load_val[5]  = FULL_ROW;
      load_val[10] = FULL_ROW;
      load_grid();
      test_clear_pass("split", 1'b0, 1'b0);
   endtask

   task automatic test_all_full();
      for (int j = 0; j < ROWS; j++) load_val[j] = FULL_ROW;
      load_grid();
      test_clear_pass("allfull", 1'b0, 1'b0);
   endtask

   task automatic test_arbitration();
      for (int j = 0; j < ROWS; j++) load_val[j] = W'(j + 100);
      load_val[12] = FULL_ROW;
      load_grid();
      test_clear_pass("arb", 1'b1, 1'b1);
      wr_req = 1'b0;
   endtask

   task automatic test_reset_mid_shift();
      for (int j = 0; j < ROWS; j++) load_val[j] = W'(j + 2);
      load_val[19] = FULL_ROW;
      load_grid();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (advance !== '1) begin
         n_fail++;
         $display("[TB] FAIL rstshift pre advance: got %h exp fffff", advance);
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, done, advance, lines_cleared} !== '0) begin
         n_fail++;
         $display("[TB] FAIL rstshift outputs: got busy=%b done=%b adv=%h lc=%0d exp all 0",
                  busy, done, advance, lines_cleared);
      end
      reset = 1'b0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rstshift quiet cyc %0d: got done=%b busy=%b exp 0 0", k, done, busy);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] v;
      for (int n = 0; n < 8; n++) begin
         for (int j = 0; j < ROWS; j++) begin
            if ($urandom_range(3) == 0) begin
               load_val[j] = FULL_ROW;
            end else begin
               v = W'($urandom);
               if (v == FULL_ROW) v[0] = 1'b0;
               load_val[j] = v;
            end
         end
         load_grid();
         test_clear_pass("random", 1'($urandom_range(1)), 1'($urandom_range(1)));
         wr_req = 1'b0;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      start    = 1'b0;
      wr_req   = 1'b0;
      load     = 1'b0;
      for (int j = 0; j < ROWS; j++) load_val[j] = '0;
      @(negedge clk);
      test_reset();
      test_empty_grid();
      test_single_row();
      test_tetris();
      test_split_rows();
      test_all_full();
      test_arbitration();
      test_reset_mid_shift();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
